// File: rtl/flatten_buffer.sv
// Ping-pong buffer that gathers per-kernel pooled pixels from the upstream lanes and
// streams each completed set kernel-major over a valid/ready handshake.
module flatten_buffer #(
    parameter int BitSize            = 32,
    parameter int NumberOfK          = 4,
    parameter int ProcessingElements = 2,
    parameter int MapWidth           = 2
) (
    input  logic                                         clk,
    input  logic                                         res_n,
    input  logic [NumberOfK-1:0]                         in_valid,
    input  logic [ProcessingElements-1:0][BitSize-1:0]   in_data,
    input  logic                                         in_set_done,
    input  logic                                         out_ready,
    output logic                                         out_valid,
    output logic [BitSize-1:0]                           out_data,
    output logic                                         out_last,
    output logic                                         overflow,
    output logic                                         set_error
);
    localparam int P     = MapWidth * MapWidth;
    localparam int DEPTH = NumberOfK * P;
    localparam int CW    = $clog2(P + 1);
    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [0:0] S_IDLE   = 1'b0;
    localparam logic [0:0] S_STREAM = 1'b1;

    logic [BitSize-1:0] mem [2][DEPTH];

    logic [CW-1:0]        cnt   [NumberOfK];
    logic [CW-1:0]        cnt_n [NumberOfK];
    logic [1:0]           full, full_n;
    logic                 fill_bank, nofree;
    logic [0:0]           state;
    logic                 drain_bank;
    logic [AW-1:0]        idx;

    logic [NumberOfK-1:0] we;
    logic                 collision, drop_err, complete, partial, early_done;
    logic                 accept, last_acc;
    logic [BitSize-1:0]   word0_fill, word0_other;

    always_comb begin
        collision = 1'b0;
        for (int i = 0; i < NumberOfK; i++)
            for (int j = i + 1; j < NumberOfK; j++)
                if (in_valid[i] && in_valid[j] && ((i % ProcessingElements) == (j % ProcessingElements)))
                    collision = 1'b1;
        collision = collision && !nofree;

        we       = '0;
        drop_err = 1'b0;
        for (int k = 0; k < NumberOfK; k++) begin
            cnt_n[k] = cnt[k];
            if (!nofree && !collision && in_valid[k]) begin
                if (cnt[k] == CW'(P)) drop_err = 1'b1;
                else begin
                    we[k]    = 1'b1;
                    cnt_n[k] = cnt[k] + CW'(1);
                end
            end
        end

        complete = !nofree;
        partial  = 1'b0;
        for (int k = 0; k < NumberOfK; k++) begin
            if (cnt_n[k] != CW'(P)) complete = 1'b0;
            if (cnt_n[k] != '0)     partial  = 1'b1;
        end
        early_done = in_set_done && !nofree && !complete && partial;

        accept   = out_valid && out_ready;
        last_acc = (state == S_STREAM) && accept && (idx == AW'(DEPTH - 1));

        full_n = full;
        if (complete) full_n[fill_bank]  = 1'b1;
        if (last_acc) full_n[drain_bank] = 1'b0;

        // Word 0 of a bank can be written in the same cycle the drain starts on it.
        word0_fill  = (we[0] && cnt[0] == '0) ? in_data[0] : mem[fill_bank][0];
        word0_other = (we[0] && cnt[0] == '0 && fill_bank == ~drain_bank) ? in_data[0]
                                                                          : mem[~drain_bank][0];
    end

    always_ff @(posedge clk) begin
        for (int k = 0; k < NumberOfK; k++)
            if (we[k])
                mem[fill_bank][AW'(k * P) + AW'(cnt[k])] <= in_data[k % ProcessingElements];
    end

    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            for (int k = 0; k < NumberOfK; k++) cnt[k] <= '0;
            full      <= '0;
            fill_bank <= 1'b0;
            nofree    <= 1'b0;
            overflow  <= 1'b0;
            set_error <= 1'b0;
        end else begin
            full <= full_n;
            if (complete) begin
                for (int k = 0; k < NumberOfK; k++) cnt[k] <= '0;
                if (!full_n[~fill_bank]) fill_bank <= ~fill_bank;
                else                     nofree    <= 1'b1;
            end else if (early_done) begin
                for (int k = 0; k < NumberOfK; k++) cnt[k] <= '0;
            end else begin
                for (int k = 0; k < NumberOfK; k++) cnt[k] <= cnt_n[k];
            end
            // While stalled the draining bank is the other one; once it frees, fill moves there.
            if (nofree && last_acc) begin
                nofree    <= 1'b0;
                fill_bank <= ~fill_bank;
            end
            if (nofree && |in_valid) overflow <= 1'b1;
            if (collision || drop_err || early_done) set_error <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            state      <= S_IDLE;
            drain_bank <= 1'b0;
            idx        <= '0;
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_last   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (complete) begin
                        state      <= S_STREAM;
                        drain_bank <= fill_bank;
                        idx        <= '0;
                        out_valid  <= 1'b1;
                        out_data   <= word0_fill;
                        out_last   <= (DEPTH == 1);
                    end
                end
                S_STREAM: begin
                    if (last_acc) begin
                        if (full_n[~drain_bank]) begin
                            drain_bank <= ~drain_bank;
                            idx        <= '0;
                            out_data   <= word0_other;
                            out_last   <= (DEPTH == 1);
                        end else begin
                            state     <= S_IDLE;
                            out_valid <= 1'b0;
                            out_last  <= 1'b0;
                        end
                    end else if (accept) begin
                        idx      <= idx + AW'(1);
                        out_data <= mem[drain_bank][idx + AW'(1)];
                        out_last <= ((idx + AW'(1)) == AW'(DEPTH - 1));
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_flatten_buffer.sv
// Self-checking bench for flatten_buffer: error-vector table, hand-written corner sequences
// and randomized sets scored against a queue of expected words.
module tb_flatten_buffer;
    localparam int NK = 4;
    localparam int PE = 2;
    localparam int P  = 4;
    localparam int SETW = NK * P;

    logic                  clk, res_n;
    logic [NK-1:0]         in_valid;
    logic [PE-1:0][31:0]   in_data;
    logic                  in_set_done, out_ready;
    logic                  out_valid, out_last, overflow, set_error;
    logic [31:0]           out_data;

    flatten_buffer #(.BitSize(32), .NumberOfK(NK), .ProcessingElements(PE), .MapWidth(2)) dut (
        .clk(clk), .res_n(res_n), .in_valid(in_valid), .in_data(in_data),
        .in_set_done(in_set_done), .out_ready(out_ready), .out_valid(out_valid),
        .out_data(out_data), .out_last(out_last), .overflow(overflow), .set_error(set_error)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct { logic [31:0] d; logic l; } word_t;
    typedef struct { logic [3:0] iv; int reps; logic err; } vec_t;

    word_t exp_q[$];
    int    n_checks = 0;
    int    n_err    = 0;
    int    popped   = 0;
    int    rmode    = 0;   // 0: ready high, 1: toggle, 2: random, 3: ready low

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk); #1;
            case (rmode)
                0: out_ready = 1'b1;
                1: out_ready = ~out_ready;
                2: out_ready = 1'($urandom_range(0, 1));
                default: out_ready = 1'b0;
            endcase
        end
    end

    // Scoreboard: every accepted word must be the next expected one; stalled words must hold.
    bit          hold_v;
    logic [31:0] hold_d;
    logic        hold_l;
    always @(negedge clk) begin
        if (!res_n) hold_v = 1'b0;
        else begin
            if (hold_v) begin
                chk("hold_valid", {31'd0, out_valid}, 32'd1);
                chk("hold_data", out_data, hold_d);
                chk("hold_last", {31'd0, out_last}, {31'd0, hold_l});
            end
            if (out_valid && out_ready) begin
                hold_v = 1'b0;
                if (exp_q.size() == 0) chk("extra_word", out_data, 32'hxxxx_xxxx);
                else begin
                    word_t w;
                    w = exp_q.pop_front();
                    chk("out_data", out_data, w.d);
                    chk("out_last", {31'd0, out_last}, {31'd0, w.l});
                    popped++;
                end
            end else if (out_valid) begin
                hold_v = 1'b1;
                hold_d = out_data;
                hold_l = out_last;
            end else hold_v = 1'b0;
        end
    end

    task automatic tick;
        @(posedge clk); #1;
    endtask

    task automatic do_reset;
        res_n = 1'b0;
        in_valid = '0;
        in_set_done = 1'b0;
        exp_q.delete();
        repeat (2) tick;
        res_n = 1'b1;
        tick;
    endtask

    // Kernel k pixel p = base+16k+p, kernels 0/1 then 2/3, two per cycle.
    task automatic send_set(input logic [31:0] base, input bit push);
        if (push)
            for (int k = 0; k < NK; k++)
                for (int p = 0; p < P; p++)
                    exp_q.push_back('{base + 32'(16 * k + p), (k == NK - 1 && p == P - 1)});
        for (int pr = 0; pr < 2; pr++)
            for (int p = 0; p < P; p++) begin
                in_valid   = (pr == 0) ? 4'b0011 : 4'b1100;
                in_data[0] = base + 32'(16 * (2 * pr) + p);
                in_data[1] = base + 32'(16 * (2 * pr + 1) + p);
                tick;
            end
        in_valid = '0;
    endtask

    task automatic send_rand_set;
        logic [31:0] w [NK][P];
        int rem [NK];
        int guard;
        logic [PE-1:0] used;
        for (int k = 0; k < NK; k++) begin
            rem[k] = P;
            for (int p = 0; p < P; p++) begin
                w[k][p] = $urandom;
                exp_q.push_back('{w[k][p], (k == NK - 1 && p == P - 1)});
            end
        end
        guard = 0;
        while ((rem[0] + rem[1] + rem[2] + rem[3]) > 0 && guard < 200) begin
            in_valid = '0;
            used     = '0;
            for (int k = 0; k < NK; k++)
                if (rem[k] > 0 && !used[k % PE] && $urandom_range(0, 2) != 0) begin
                    used[k % PE]   = 1'b1;
                    in_valid[k]    = 1'b1;
                    in_data[k % PE] = w[k][P - rem[k]];
                    rem[k]--;
                end
            tick;
            guard++;
        end
        in_valid = '0;
        chk("rand_fill_timeout", 32'(guard >= 200), 32'd0);
    endtask

    task automatic wait_drain(input int budget, output int cyc);
        cyc = 0;
        while (exp_q.size() > 0 && cyc < budget) begin
            @(posedge clk);
            cyc++;
        end
        #1;
        chk("drain_timeout", 32'(exp_q.size()), 32'd0);
    endtask

    vec_t tbl [8];
    int   cyc, p0, sent, guard;

    initial begin
        tbl[0] = '{4'b0101, 1, 1'b1};
        tbl[1] = '{4'b1010, 1, 1'b1};
        tbl[2] = '{4'b1111, 1, 1'b1};
        tbl[3] = '{4'b0011, 4, 1'b0};
        tbl[4] = '{4'b0011, 5, 1'b1};
        tbl[5] = '{4'b0110, 3, 1'b0};
        tbl[6] = '{4'b1001, 4, 1'b0};
        tbl[7] = '{4'b0001, 5, 1'b1};

        res_n = 1'b0; in_valid = '0; in_data = '0; in_set_done = 1'b0;
        #12;
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_out_data", out_data, 32'd0);
        chk("rst_out_last", {31'd0, out_last}, 32'd0);
        chk("rst_overflow", {31'd0, overflow}, 32'd0);
        chk("rst_set_error", {31'd0, set_error}, 32'd0);
        do_reset;

        // Single set at full throughput.
        send_set(32'd0, 1'b1);
        chk("t1_latency_valid", {31'd0, out_valid}, 32'd1);
        chk("t1_first_word", out_data, 32'd0);
        wait_drain(100, cyc);
        chk("t1_cycles", 32'(cyc), 32'd16);
        chk("t1_idle_valid", {31'd0, out_valid}, 32'd0);
        chk("t1_idle_hold", out_data, 32'd51);
        chk("t1_flags", {30'd0, overflow, set_error}, 32'd0);

        // Backpressure toggling.
        p0 = popped;
        rmode = 1;
        send_set(32'd0, 1'b1);
        wait_drain(200, cyc);
        chk("t2_words", 32'(popped - p0), 32'd16);

        // Back-to-back sets, second fills during first drain.
        rmode = 0; tick;
        p0 = popped;
        send_set(32'h100, 1'b1);
        send_set(32'h200, 1'b1);
        wait_drain(200, cyc);
        chk("t3_no_gap", 32'(cyc), 32'd24);
        chk("t3_words", 32'(popped - p0), 32'd32);
        chk("t3_overflow", {31'd0, overflow}, 32'd0);

        // Overflow: both banks full, third set dropped.
        do_reset;
        rmode = 3; tick;
        p0 = popped;
        send_set(32'h1000, 1'b1);
        send_set(32'h2000, 1'b1);
        send_set(32'h3000, 1'b0);
        chk("t4_overflow", {31'd0, overflow}, 32'd1);
        chk("t4_set_error", {31'd0, set_error}, 32'd0);
        chk("t4_stall_word", out_data, 32'h1000);
        rmode = 0;
        wait_drain(200, cyc);
        repeat (20) tick;
        chk("t4_words", 32'(popped - p0), 32'd32);

        // Early in_set_done discards the partial set.
        do_reset;
        in_valid = 4'b0001; in_data = '{32'hdead, 32'hbeef};
        tick; tick;
        in_valid = '0; in_set_done = 1'b1;
        tick;
        in_set_done = 1'b0;
        repeat (6) tick;
        chk("t5_set_error", {31'd0, set_error}, 32'd1);
        chk("t5_no_output", {31'd0, out_valid}, 32'd0);
        send_set(32'h300, 1'b1);
        chk("t5_restart_word0", out_data, 32'h300);
        wait_drain(100, cyc);
        chk("t5_cycles", 32'(cyc), 32'd16);

        // Error table: collisions and over-delivery.
        for (int i = 0; i < 8; i++) begin
            do_reset;
            for (int r = 0; r < tbl[i].reps; r++) begin
                in_valid = tbl[i].iv;
                in_data  = {$urandom, $urandom};
                tick;
            end
            in_valid = '0;
            tick;
            chk($sformatf("tbl%0d_set_error", i), {31'd0, set_error}, {31'd0, tbl[i].err});
            chk($sformatf("tbl%0d_no_output", i), {31'd0, out_valid}, 32'd0);
            chk($sformatf("tbl%0d_overflow", i), {31'd0, overflow}, 32'd0);
        end

        // Collision must not advance counters: a following set lands at address 0.
        do_reset;
        in_valid = 4'b0101; in_data = '{32'h77, 32'h66};
        tick;
        in_valid = '0;
        send_set(32'h400, 1'b1);
        chk("t6_word0", out_data, 32'h400);
        wait_drain(100, cyc);
        chk("t6_cycles", 32'(cyc), 32'd16);

        // Reset in the middle of a stream.
        send_set(32'h500, 1'b1);
        repeat (3) tick;
        chk("t7_pre_err", {31'd0, set_error}, 32'd1);
        #2 res_n = 1'b0;
        #1;
        chk("t7_rst_valid", {31'd0, out_valid}, 32'd0);
        chk("t7_rst_flags", {30'd0, overflow, set_error}, 32'd0);
        exp_q.delete();
        tick;
        res_n = 1'b1;
        tick;

        // Randomized sets with random backpressure.
        rmode = 2;
        p0 = popped;
        sent = 0;
        for (int s = 0; s < 25; s++) begin
            guard = 0;
            while ((sent - (popped - p0) / SETW) > 1 && guard < 500) begin
                tick;
                guard++;
            end
            chk("rand_throttle", 32'(guard >= 500), 32'd0);
            send_rand_set;
            sent++;
            repeat ($urandom_range(0, 6)) tick;
        end
        wait_drain(3000, cyc);
        chk("rand_words", 32'(popped - p0), 32'(25 * SETW));
        chk("rand_flags", {30'd0, overflow, set_error}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end
endmodule
